// File: rtl/if_inst_queue.sv
// Fetch-to-decode instruction queue: in-order FIFO of {pc, inst} pairs.
// It applies PC back-pressure when full and discards wrong-path entries while keeping the branch delay slot.
module if_inst_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall_id,
  input  logic             branch_flag,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_inst,
  output logic             if_stall,
  output logic             id_valid,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_inst,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] TWO  = (PTR_W+1)'(2);

  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count_q;
  logic             deq, enq_req, ds_keep;

  assign id_valid = (count_q != '0);
  assign if_stall = (count_q == FULL);
  assign id_pc    = id_valid ? pc_q[head]   : '0;
  assign id_inst  = id_valid ? inst_q[head] : '0;
  assign count    = count_q;

  assign deq     = id_valid && !stall_id;
  assign enq_req = if_valid && !if_stall;
  // A taken branch with at least two entries queued keeps only the delay slot behind it.
  // With one entry queued, the delay slot is the next fetch, so a normal enqueue handles it.
  assign ds_keep = branch_flag && deq && (count_q >= TWO);

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (ds_keep) begin
      head    <= head + PTR_W'(1);
      tail    <= head + PTR_W'(2);
      count_q <= (PTR_W+1)'(1);
    end else begin
      if (enq_req) begin
        pc_q[tail]   <= if_pc;
        inst_q[tail] <= if_inst;
        tail         <= tail + PTR_W'(1);
      end
      if (deq) head <= head + PTR_W'(1);
      count_q <= count_q + (PTR_W+1)'(enq_req) - (PTR_W+1)'(deq);
    end
  end

endmodule

// File: tb/tb_if_inst_queue.sv
// Randomized and directed check of if_inst_queue against a queue-based reference model.
module tb_if_inst_queue;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 0;
  logic             rst = 1, flush = 0, stall_id = 0, branch_flag = 0, if_valid = 0;
  logic [31:0]      if_pc = 0, if_inst = 0;
  logic             if_stall, id_valid;
  logic [31:0]      id_pc, id_inst;
  logic [PTR_W:0]   count;

  int n_tests = 0, n_fail = 0;
  logic [63:0] mq [$];
  logic [31:0] cur_pc;

  if_inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_id(stall_id),
    .branch_flag(branch_flag), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_stall(if_stall), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h @%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare all outputs after the edge.
  task automatic step(input logic r, input logic f, input logic s, input logic b, input logic v);
    logic [31:0] ip, ii;
    logic [63:0] e;
    bit enq, dq;
    ip = cur_pc;
    ii = $urandom;
    rst = r; flush = f; stall_id = s; branch_flag = b; if_valid = v;
    if_pc = ip; if_inst = ii;
    enq = v && (mq.size() < DEPTH);
    dq  = (mq.size() != 0) && !s;
    if (r || f) mq.delete();
    else if (b && dq && mq.size() >= 2) begin
      e = mq[1];
      mq.delete();
      mq.push_back(e);
    end else begin
      if (dq) void'(mq.pop_front());
      if (enq) mq.push_back({ip, ii});
    end
    if (enq) cur_pc += 4;
    @(posedge clk);
    #1;
    chk("count", 32'(count), 32'(mq.size()));
    chk("id_valid", 32'(id_valid), 32'(mq.size() != 0));
    chk("if_stall", 32'(if_stall), 32'(mq.size() == DEPTH));
    chk("id_pc", id_pc, mq.size() != 0 ? mq[0][63:32] : 32'h0);
    chk("id_inst", id_inst, mq.size() != 0 ? mq[0][31:0] : 32'h0);
  endtask

  initial begin
    cur_pc = 32'hBFC0_0000;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(id_valid), 0);

    // Streaming: every fetch is consumed, so occupancy stays at one.
    step(0, 0, 0, 0, 1); chk("stream_pc0", id_pc, 32'hBFC0_0000);
    step(0, 0, 0, 0, 1); chk("stream_pc1", id_pc, 32'hBFC0_0004);
    step(0, 0, 0, 0, 1); chk("stream_pc2", id_pc, 32'hBFC0_0008);
    chk("stream_count", 32'(count), 1);

    // Fill to full while ID stalls, then free one slot for a single cycle.
    step(1, 0, 0, 0, 0);
    cur_pc = 32'h0000_1000;
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 1);
    chk("full_stall", 32'(if_stall), 1);
    chk("held_pc", cur_pc, 32'h0000_1010);
    step(0, 0, 0, 0, 1);
    chk("one_deq_count", 32'(count), 3);
    chk("one_deq_stall", 32'(if_stall), 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, i < 2);

    // Taken branch with more than one entry queued: only the delay slot survives.
    step(1, 0, 0, 0, 0);
    cur_pc = 32'h100;
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 1);
    chk("br_count", 32'(count), 1);
    chk("br_ds_pc", id_pc, 32'h104);
    cur_pc = 32'h200;
    step(0, 0, 1, 0, 1);
    chk("br_target_count", 32'(count), 2);
    step(0, 0, 0, 0, 0);
    chk("br_target_pc", id_pc, 32'h200);

    // Taken branch with a single entry queued: the incoming fetch is the delay slot.
    step(1, 0, 0, 0, 0);
    cur_pc = 32'h100;
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 1);
    chk("br1_count", 32'(count), 1);
    chk("br1_pc", id_pc, 32'h104);

    // Flush and reset in the middle of a fill.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1);
    step(0, 1, 1, 0, 1);
    chk("flush_count", 32'(count), 0);
    chk("flush_pc", id_pc, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 1);
    step(1, 0, 1, 0, 1);
    chk("rst_mid_count", 32'(count), 0);
    chk("rst_mid_stall", 32'(if_stall), 0);

    // Random traffic with occasional redirects.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) cur_pc = $urandom & 32'hFFFF_FFFC;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
